// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//
// Shared types for the sequential ALU (seq_alu) and its combinational
// core (alu_core).
//
//   op_t     4-bit opcode encoding seen on seq_alu.op
//   state_t  sequencer states (IDLE, BUSY, DONE)
//   flags_t  packed status flags {cf, zf, sf, vf}
//   is_shift helper: true for the five shift/rotate opcodes
//
// Optional feature macro used by the design files: SEQ_ALU_MUL_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_ADC   = 4'h1,
        OP_SUB   = 4'h2,
        OP_SBC   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_XOR   = 4'h6,
        OP_NOT   = 4'h7,
        OP_SHL   = 4'h8,
        OP_SHR   = 4'h9,
        OP_SAR   = 4'hA,
        OP_ROL   = 4'hB,
        OP_ROR   = 4'hC,
        OP_MUL   = 4'hD,
        OP_PASS  = 4'hE,
        OP_PASS2 = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic cf;
        logic zf;
        logic sf;
        logic vf;
    } flags_t;

    function automatic logic is_shift(input op_t op_in);
        return (op_in == OP_SHL) || (op_in == OP_SHR) || (op_in == OP_SAR) ||
               (op_in == OP_ROL) || (op_in == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//
// Purely combinational single-cycle part of the sequential ALU. Handles
// ADD/ADC/SUB/SBC, AND/OR/XOR/NOT and PASS. Any other opcode (shifts, MUL)
// yields o=0 with cf=vf=0; seq_alu never uses the core result for those,
// except MUL in a build without the multiplier where exactly that zero
// result is wanted.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//
// Ports:
//   op     opcode (alu_pkg::op_t)
//   a, b   operands
//   ci     carry in, used by ADC and SBC
//   o      result
//   flags  {cf, zf, sf, vf}
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] o,
    output flags_t           flags
);

    logic [WIDTH-1:0] y;      // second addend: b or ~b
    logic             cin;
    logic             arith;
    logic [WIDTH:0]   sum;

    // All four arithmetic ops share one adder; subtraction is a + ~b + cin.
    always_comb begin
        y     = b;
        cin   = 1'b0;
        arith = 1'b0;
        case (op)
            OP_ADD: begin y = b;  cin = 1'b0; arith = 1'b1; end
            OP_ADC: begin y = b;  cin = ci;   arith = 1'b1; end
            OP_SUB: begin y = ~b; cin = 1'b1; arith = 1'b1; end
            OP_SBC: begin y = ~b; cin = ci;   arith = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        o = '0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: o = sum[WIDTH-1:0];
            OP_AND:                         o = a & b;
            OP_OR:                          o = a | b;
            OP_XOR:                         o = a ^ b;
            OP_NOT:                         o = ~a;
            OP_PASS, OP_PASS2:              o = a;
            default:                        o = '0;
        endcase

        // For SUB/SBC the carry out doubles as "no borrow".
        flags.cf = arith & sum[WIDTH];
        flags.zf = (o == '0);
        flags.sf = o[WIDTH-1];
        flags.vf = arith && (a[WIDTH-1] == y[WIDTH-1]) && (o[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//
// Multi-cycle ALU between register-file read and writeback. Single-cycle
// ops (arithmetic, logic, PASS) come from alu_core; shifts and rotates step
// one bit per cycle, and MUL is an unsigned shift-add multiplier taking
// WIDTH cycles. Operands are captured on the accepting edge, so input
// changes while BUSY or DONE have no effect.
//
// Latency from accept edge to out_valid:
//   1            single-cycle ops, shifts by 0, MUL when not built
//   amount+1     shifts/rotates (amount = b[SHW-1:0])
//   WIDTH+1      MUL
//
// Optional feature macro: SEQ_ALU_MUL_EN
//   defined   : multiplier datapath present, {hi,o} = a*b
//   undefined : op D completes in one cycle with o=0, hi=0, zf=1, others 0
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   SHW    shift-amount width, $clog2(WIDTH), not overridable
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (op, a, b, ci)
//   out_valid/out_ready result handshake
//   o                  result (low half for MUL)
//   hi                 MUL high half, 0 otherwise
//   cf, zf, sf, vf     carry, zero, sign, signed overflow
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] hi,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             vf
);

    // Counter must hold WIDTH for MUL, so one bit wider than SHW.
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    op_t              op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work_lo;
    flags_t           flags_r;

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   psum;
    logic [WIDTH-1:0] step_hi;
`endif

    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] core_o;
    flags_t           core_flags;
    logic [WIDTH-1:0] imm_o;
    flags_t           imm_flags;
    logic [WIDTH-1:0] step_lo;
    logic             step_c;
    logic [WIDTH-1:0] done_hi;
    logic             done_cf;

    assign amt = b[SHW-1:0];

    assign cf = flags_r.cf;
    assign zf = flags_r.zf;
    assign sf = flags_r.sf;
    assign vf = flags_r.vf;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op    (op),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .o     (core_o),
        .flags (core_flags)
    );

    // Result for anything that finishes on the accepting edge. A shift by 0
    // passes a through with cf=0; MUL only gets here when not built.
    always_comb begin
        imm_o     = core_o;
        imm_flags = core_flags;
        if (is_shift(op)) begin
            imm_o        = a;
            imm_flags.cf = 1'b0;
            imm_flags.zf = (a == '0);
            imm_flags.sf = a[WIDTH-1];
            imm_flags.vf = 1'b0;
        end else if (op == OP_MUL) begin
            imm_o        = '0;
            imm_flags.cf = 1'b0;
            imm_flags.zf = 1'b1;
            imm_flags.sf = 1'b0;
            imm_flags.vf = 1'b0;
        end
    end

    // One iteration of the latched shift/rotate or multiply. step_c is the
    // bit leaving the word this cycle; after the final step it is the
    // "last bit shifted out" carry.
    always_comb begin
        step_lo = work_lo;
        step_c  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        step_hi = work_hi;
        psum    = '0;
`endif
        case (op_r)
            OP_SHL: begin
                step_lo = {work_lo[WIDTH-2:0], 1'b0};
                step_c  = work_lo[WIDTH-1];
            end
            OP_SHR: begin
                step_lo = {1'b0, work_lo[WIDTH-1:1]};
                step_c  = work_lo[0];
            end
            OP_SAR: begin
                step_lo = {work_lo[WIDTH-1], work_lo[WIDTH-1:1]};
                step_c  = work_lo[0];
            end
            OP_ROL: begin
                step_lo = {work_lo[WIDTH-2:0], work_lo[WIDTH-1]};
                step_c  = work_lo[WIDTH-1];
            end
            OP_ROR: begin
                step_lo = {work_lo[0], work_lo[WIDTH-1:1]};
                step_c  = work_lo[0];
            end
`ifdef SEQ_ALU_MUL_EN
            // Shift-add: multiplier bits are consumed from work_lo[0] while
            // product bits shift in from the top, so after WIDTH steps
            // {work_hi, work_lo} holds the full product.
            OP_MUL: begin
                psum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mcand} : '0);
                step_hi = psum[WIDTH:1];
                step_lo = {psum[0], work_lo[WIDTH-1:1]};
            end
`endif
            default: ;
        endcase

`ifdef SEQ_ALU_MUL_EN
        done_hi = (op_r == OP_MUL) ? step_hi : '0;
        done_cf = (op_r == OP_MUL) ? (step_hi != '0) : step_c;
`else
        done_hi = '0;
        done_cf = step_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            o          <= '0;
            hi         <= '0;
            flags_r.cf <= 1'b0;
            flags_r.zf <= 1'b1;
            flags_r.sf <= 1'b0;
            flags_r.vf <= 1'b0;
        end else begin
            case (state)
                // ---- IDLE: accept and either finish now or start iterating
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        in_ready <= 1'b0;
                        if (is_shift(op) && (amt != '0)) begin
                            state   <= BUSY;
                            cnt     <= CW'(amt);
                            work_lo <= a;
                        end
`ifdef SEQ_ALU_MUL_EN
                        else if (op == OP_MUL) begin
                            state   <= BUSY;
                            cnt     <= CW'(WIDTH);
                            work_lo <= a;
                            work_hi <= '0;
                            mcand   <= b;
                        end
`endif
                        else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            o         <= imm_o;
                            hi        <= '0;
                            flags_r   <= imm_flags;
                        end
                    end
                end

                // ---- BUSY: one step per cycle, publish on the last one
                BUSY: begin
                    work_lo <= step_lo;
`ifdef SEQ_ALU_MUL_EN
                    work_hi <= step_hi;
`endif
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        o          <= step_lo;
                        hi         <= done_hi;
                        flags_r.cf <= done_cf;
                        flags_r.zf <= (step_lo == '0);
                        flags_r.sf <= step_lo[WIDTH-1];
                        flags_r.vf <= 1'b0;
                    end
                end

                // ---- DONE: hold result until consumed; in_ready returns
                // only after the handshake edge, so no same-cycle accept.
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;
    localparam int M = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o;
    logic [W-1:0] hi;
    logic         cf, zf, sf, vf;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .hi        (hi),
        .cf        (cf),
        .zf        (zf),
        .sf        (sf),
        .vf        (vf)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int last_o, last_hi, last_cf, last_zf, last_sf, last_vf, last_lat;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    // Reference behaviour from plain integer arithmetic.
    function automatic void model(input int opc, input int av, input int bv, input int civ,
                                  output int eo, output int ehi, output int ecf,
                                  output int evf, output int elat);
        int n, addend, cin, s, ss;
        longint p;
        n    = bv % W;
        eo   = 0; ehi = 0; ecf = 0; evf = 0; elat = 1;
        case (opc)
            0, 1, 2, 3: begin
                addend = (opc < 2) ? bv : (M - bv);
                cin    = (opc == 0) ? 0 : (opc == 2) ? 1 : civ;
                s      = av + addend + cin;
                eo     = s & M;
                ecf    = (s >> W) & 1;
                ss     = sx(av) + sx(addend) + cin;
                evf    = int'((ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1))));
            end
            4: eo = av & bv;
            5: eo = av | bv;
            6: eo = av ^ bv;
            7: eo = (~av) & M;
            8: begin
                eo = (av << n) & M;
                ecf = (n != 0) ? (av >> (W - n)) & 1 : 0;
                elat = n + 1;
            end
            9: begin
                eo = av >> n;
                ecf = (n != 0) ? (av >> (n - 1)) & 1 : 0;
                elat = n + 1;
            end
            10: begin
                eo = (sx(av) >>> n) & M;
                ecf = (n != 0) ? (av >> (n - 1)) & 1 : 0;
                elat = n + 1;
            end
            11: begin
                eo = ((av << n) | (av >> (W - n))) & M;
                ecf = (n != 0) ? (eo & 1) : 0;
                elat = n + 1;
            end
            12: begin
                eo = ((av >> n) | (av << (W - n))) & M;
                ecf = (n != 0) ? ((eo >> (W - 1)) & 1) : 0;
                elat = n + 1;
            end
            13: begin
`ifdef SEQ_ALU_MUL_EN
                p    = longint'(av) * longint'(bv);
                eo   = int'(p & M);
                ehi  = int'(p >> W);
                ecf  = int'(ehi != 0);
                elat = W + 1;
`else
                p    = 0;
`endif
            end
            default: eo = av;
        endcase
    endfunction

    task automatic run_op(input int opc, input int av, input int bv, input int civ, input int hold);
        int eo, ehi, ecf, evf, elat, ezf, esf, lat, res0;
        logic [3:0] r4;
        model(opc, av, bv, civ, eo, ehi, ecf, evf, elat);
        ezf = int'(eo == 0);
        esf = (eo >> (W - 1)) & 1;
        chk("in_ready_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        r4 = opc[3:0];
        op = op_t'(r4);
        a  = av[W-1:0];
        b  = bv[W-1:0];
        ci = civ[0];
        @(posedge clk); #1;
        // Scramble inputs after acceptance; they must be ignored.
        in_valid = 1'b0;
        r4 = 4'($urandom_range(0, 15));
        op = op_t'(r4);
        a  = W'($urandom);
        b  = W'($urandom);
        ci = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency op%0h", opc), lat, elat);
        chk($sformatf("result op%0h a=%0h b=%0h ci=%0d {o,hi,c,z,s,v}", opc, av, bv, civ),
            int'({o, hi, cf, zf, sf, vf}),
            (eo << 12) | (ehi << 4) | (ecf << 3) | (ezf << 2) | (esf << 1) | evf);
        chk("in_ready_done", int'(in_ready), 0);
        res0 = int'({o, hi, cf, zf, sf, vf});
        last_o = int'(o); last_hi = int'(hi); last_cf = int'(cf);
        last_zf = int'(zf); last_sf = int'(sf); last_vf = int'(vf); last_lat = lat;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_stable", int'({o, hi, cf, zf, sf, vf}), res0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
    endtask

    initial begin
        int cnt_v, seen_o, seen_cf;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = OP_ADD; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_o_hi", int'({o, hi}), 0);
        chk("rst_flags", int'({cf, zf, sf, vf}), 4'b0100);

        // Directed test-plan items
        run_op(0, 'hFF, 'h01, 0, 0);
        chk("add_o", last_o, 0); chk("add_cf", last_cf, 1); chk("add_zf", last_zf, 1);
        chk("add_vf", last_vf, 0); chk("add_lat", last_lat, 1);

        run_op(2, 'h80, 'h01, 0, 1);
        chk("sub_o", last_o, 'h7F); chk("sub_cf", last_cf, 1);
        chk("sub_vf", last_vf, 1); chk("sub_sf", last_sf, 0);

        run_op(3, 'h00, 'h00, 0, 0);
        chk("sbc_o", last_o, 'hFF); chk("sbc_cf", last_cf, 0);

        run_op(12, 'h81, 'h03, 0, 0);
        chk("ror_lat", last_lat, 4); chk("ror_o", last_o, 'h30); chk("ror_cf", last_cf, 0);

        run_op(10, 'h80, 'h07, 0, 2);
        chk("sar_o", last_o, 'hFF); chk("sar_cf", last_cf, 0); chk("sar_lat", last_lat, 8);

        run_op(9, 'h5A, 'h08, 0, 0);   // amount 8 reduces to 0
        chk("shr0_o", last_o, 'h5A); chk("shr0_cf", last_cf, 0); chk("shr0_lat", last_lat, 1);

        run_op(13, 'hFF, 'hFF, 0, 0);
`ifdef SEQ_ALU_MUL_EN
        chk("mul_lat", last_lat, 9); chk("mul_hi", last_hi, 'hFE);
        chk("mul_o", last_o, 'h01); chk("mul_cf", last_cf, 1);
`else
        chk("mul_lat", last_lat, 1); chk("mul_o", last_o, 0);
        chk("mul_hi", last_hi, 0); chk("mul_zf", last_zf, 1); chk("mul_cf", last_cf, 0);
`endif

        // Backpressure: result held, second bundle refused
        in_valid = 1'b1; op = OP_XOR; a = 8'h5A; b = 8'h0F; ci = 1'b0;
        @(posedge clk); #1;
        op = OP_ADD; a = 8'h01; b = 8'h01;   // second bundle kept valid
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_o", int'(o), 'h55);
            chk("bp_flags", int'({cf, zf, sf, vf}), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_no_accept", int'(out_valid), 0);
        chk("bp_idle_ready", int'(in_ready), 1);

        // out_ready held high: exactly one valid cycle
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_ROL; a = 8'h81; b = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt_v = 0; seen_o = -1; seen_cf = -1;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) begin
                cnt_v++; seen_o = int'(o); seen_cf = int'(cf);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("one_valid_count", cnt_v, 1);
        chk("rol_o", seen_o, 'h03);
        chk("rol_cf", seen_cf, 1);

        // Reset in the middle of a long shift
        in_valid = 1'b1; op = OP_ROR; a = 8'hC3; b = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_ready", int'(in_ready), 1);
        chk("rst_mid_zf", int'(zf), 1);
        chk("rst_mid_o", int'(o), 0);
        cnt_v = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) cnt_v++;
        end
        chk("rst_mid_no_output", cnt_v, 0);

`ifdef SEQ_ALU_MUL_EN
        // Reset at BUSY cycle 3 of a multiply
        in_valid = 1'b1; op = OP_MUL; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mul_valid", int'(out_valid), 0);
        chk("rst_mul_zf", int'(zf), 1);
        chk("rst_mul_hi", int'(hi), 0);
        cnt_v = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) cnt_v++;
        end
        chk("rst_mul_no_output", cnt_v, 0);
`endif

        run_op(0, 2, 3, 0, 0);
        chk("post_rst_add", last_o, 'h05);

        // Randomised operations against the reference model
        for (int i = 0; i < 80; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, M)),
                   int'($urandom_range(0, M)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
